mgmt_bus_arbiter: RTL and testbench

//  Shares the single 16-bit-address / 8-bit-data management register bus between NUM_PORTS bridge requesters (simulation pipe bridge, MCU QSPI bridge, ...).

---
 rtl/mgmt_arb_pkg.sv | 20 ++
 rtl/mgmt_rr_picker.sv | 31 +++
 rtl/mgmt_bus_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_mgmt_bus_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mgmt_arb_pkg.sv
// Shared types and widths for the management bus arbiter.
// The optional lock feature is enabled by defining MGMT_ARB_LOCK_EN.
package mgmt_arb_pkg;

   localparam int MGMT_ADDR_W = 16;
   localparam int MGMT_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ISSUE = 3'd1,
      RD_WAIT  = 3'd2,
      WRITE    = 3'd3,
      DONE     = 3'd4
   } arb_state_t;

   function automatic int unsigned next_port(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mgmt_rr_picker.sv
// Combinational round-robin picker: the first requester at or after ptr_i wins.
// Returns a one-hot grant, its index and an any-request flag.
module mgmt_rr_picker #(
   parameter int NUM_PORTS = 2,
   parameter int IDX_W     = 1
) (
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [IDX_W-1:0]     ptr_i,
   output logic [NUM_PORTS-1:0] gnt_o,
   output logic [IDX_W-1:0]     idx_o,
   output logic                 any_o
);

   int unsigned cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand = (int'(ptr_i) + i) % NUM_PORTS;
         if (!any_o && req_i[cand]) begin
            any_o       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/mgmt_bus_arbiter.sv
// Round-robin arbiter sharing the management register bus between burst requesters.
// Define MGMT_ARB_LOCK_EN to add req_lock_i for atomic back-to-back bursts.
//   state    | meaning
//   IDLE     | pick next requester, accept descriptor
//   RD_ISSUE | one-cycle rd_en at current address
//   RD_WAIT  | wait for rd_valid or timeout
//   WRITE    | forward write bytes as they arrive
//   DONE     | pulse xfer_done/xfer_err, advance pointer
module mgmt_bus_arbiter
   import mgmt_arb_pkg::*;
#(
   parameter int NUM_PORTS      = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                             clk_i,
   input  logic                             rst_n_i,
   input  logic [NUM_PORTS-1:0]             req_valid_i,
   output logic [NUM_PORTS-1:0]             req_ready_o,
   input  logic [NUM_PORTS-1:0]             req_write_i,
   input  logic [NUM_PORTS*MGMT_ADDR_W-1:0] req_addr_i,
   input  logic [NUM_PORTS*16-1:0]          req_len_i,
`ifdef MGMT_ARB_LOCK_EN
   input  logic [NUM_PORTS-1:0]             req_lock_i,
`endif
   input  logic [NUM_PORTS-1:0]             wdata_valid_i,
   output logic [NUM_PORTS-1:0]             wdata_ready_o,
   input  logic [NUM_PORTS*MGMT_DATA_W-1:0] wdata_i,
   output logic [NUM_PORTS-1:0]             rdata_valid_o,
   output logic [MGMT_DATA_W-1:0]           rdata_o,
   output logic [NUM_PORTS-1:0]             xfer_done_o,
   output logic [NUM_PORTS-1:0]             xfer_err_o,
   output logic                             rd_en_o,
   output logic [MGMT_ADDR_W-1:0]           rd_addr_o,
   input  logic                             rd_valid_i,
   input  logic [MGMT_DATA_W-1:0]           rd_data_i,
   output logic                             wr_en_o,
   output logic [MGMT_ADDR_W-1:0]           wr_addr_o,
   output logic [MGMT_DATA_W-1:0]           wr_data_o
);

   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   arb_state_t             state_q, state_d;
   logic [IDX_W-1:0]       gnt_q, gnt_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic                   write_q, write_d;
   logic [MGMT_ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]            len_q, len_d;
   logic [15:0]            cnt_q, cnt_d;
   logic [15:0]            cnt_inc;
   logic                   err_q, err_d;
   logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
   logic                   rdata_valid_q, rdata_valid_d;
   logic [MGMT_DATA_W-1:0] rdata_q, rdata_d;
   logic                   wr_en_q, wr_en_d;
   logic [MGMT_ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [MGMT_DATA_W-1:0] wr_data_q, wr_data_d;
   logic                   armed_q;

   logic [NUM_PORTS-1:0]   gnt_vec;
   logic [NUM_PORTS-1:0]   req_elig;
   logic [NUM_PORTS-1:0]   pick_gnt;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_any;

   assign gnt_vec = NUM_PORTS'(1) << gnt_q;
   assign cnt_inc = cnt_q + 16'd1;

`ifdef MGMT_ARB_LOCK_EN
   logic lock_q, lock_d, lock_hold;

   // A held lock restricts eligibility to the port that owned the last burst.
   assign lock_hold = lock_q & req_lock_i[gnt_q];
   assign req_elig  = lock_hold ? (req_valid_i & gnt_vec) : req_valid_i;

   always_comb begin
      lock_d = lock_q;
      if (state_q == IDLE) begin
         lock_d = lock_hold;
      end else if (state_q == DONE) begin
         lock_d = req_lock_i[gnt_q];
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lock_q <= 1'b0;
      end else begin
         lock_q <= lock_d;
      end
   end
`else
   assign req_elig = req_valid_i;
`endif

   mgmt_rr_picker #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_picker (
      .req_i (req_elig),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   // armed_q keeps the combinational ready low until the first clock after reset.
   assign req_ready_o   = (state_q == IDLE && armed_q) ? pick_gnt : '0;
   assign wdata_ready_o = (state_q == WRITE) ? gnt_vec : '0;
   assign xfer_done_o   = (state_q == DONE) ? gnt_vec : '0;
   assign xfer_err_o    = (state_q == DONE && err_q) ? gnt_vec : '0;
   assign rdata_valid_o = rdata_valid_q ? gnt_vec : '0;
   assign rdata_o       = rdata_q;
   assign rd_en_o       = (state_q == RD_ISSUE);
   assign rd_addr_o     = addr_q;
   assign wr_en_o       = wr_en_q;
   assign wr_addr_o     = wr_addr_q;
   assign wr_data_o     = wr_data_q;

   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt_q;
      ptr_d         = ptr_q;
      write_d       = write_q;
      addr_d        = addr_q;
      len_d         = len_q;
      cnt_d         = cnt_q;
      err_d         = err_q;
      to_cnt_d      = to_cnt_q;
      rdata_valid_d = 1'b0;
      rdata_d       = rdata_q;
      wr_en_d       = 1'b0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;

      unique case (state_q)
         IDLE: begin
            if (armed_q && pick_any) begin
               gnt_d   = pick_idx;
               write_d = req_write_i[pick_idx];
               addr_d  = req_addr_i[int'(pick_idx)*MGMT_ADDR_W +: MGMT_ADDR_W];
               len_d   = req_len_i[int'(pick_idx)*16 +: 16];
               cnt_d   = '0;
               err_d   = 1'b0;
               if (req_len_i[int'(pick_idx)*16 +: 16] == 16'd0) begin
                  state_d = DONE;
               end else if (req_write_i[pick_idx]) begin
                  state_d = WRITE;
               end else begin
                  state_d = RD_ISSUE;
               end
            end
         end
         RD_ISSUE: begin
            to_cnt_d = TO_LOAD;
            state_d  = RD_WAIT;
         end
         RD_WAIT: begin
            // rd_valid takes precedence over a timeout expiring in the same cycle.
            if (rd_valid_i) begin
               rdata_d       = rd_data_i;
               rdata_valid_d = 1'b1;
               cnt_d         = cnt_inc;
               addr_d        = addr_q + 16'd1;
               state_d       = (cnt_inc == len_q) ? DONE : RD_ISSUE;
            end else if (TIMEOUT_CYCLES != 0 && to_cnt_q == '0) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               to_cnt_d = to_cnt_q - 1'b1;
            end
         end
         WRITE: begin
            if (wdata_valid_i[gnt_q]) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = wdata_i[int'(gnt_q)*MGMT_DATA_W +: MGMT_DATA_W];
               cnt_d     = cnt_inc;
               addr_d    = addr_q + 16'd1;
               if (cnt_inc == len_q) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
`ifdef MGMT_ARB_LOCK_EN
            if (!req_lock_i[gnt_q]) begin
               ptr_d = IDX_W'(next_port(int'(gnt_q), NUM_PORTS));
            end
`else
            ptr_d = IDX_W'(next_port(int'(gnt_q), NUM_PORTS));
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q       <= IDLE;
         gnt_q         <= '0;
         ptr_q         <= '0;
         write_q       <= 1'b0;
         addr_q        <= '0;
         len_q         <= '0;
         cnt_q         <= '0;
         err_q         <= 1'b0;
         to_cnt_q      <= '0;
         rdata_valid_q <= 1'b0;
         rdata_q       <= '0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         armed_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         ptr_q         <= ptr_d;
         write_q       <= write_d;
         addr_q        <= addr_d;
         len_q         <= len_d;
         cnt_q         <= cnt_d;
         err_q         <= err_d;
         to_cnt_q      <= to_cnt_d;
         rdata_valid_q <= rdata_valid_d;
         rdata_q       <= rdata_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         armed_q       <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mgmt_bus_arbiter.sv
// Scoreboard bench for mgmt_bus_arbiter: directed bursts plus randomized traffic
// against a burst-level model; lock ordering is exercised when MGMT_ARB_LOCK_EN is defined.
module tb_mgmt_bus_arbiter;

   localparam int NP = 2;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              tb_req_valid [NP];
   logic              tb_req_write [NP];
   logic [15:0]       tb_addr      [NP];
   logic [15:0]       tb_len       [NP];
   logic              tb_wvalid    [NP];
   logic [7:0]        tb_wdata     [NP];
   logic              tb_lock      [NP];

   logic [NP-1:0]     req_valid, req_ready, req_write, req_lock;
   logic [NP*16-1:0]  req_addr, req_len;
   logic [NP-1:0]     wdata_valid, wdata_ready;
   logic [NP*8-1:0]   wdata;
   logic [NP-1:0]     rdata_valid, xfer_done, xfer_err;
   logic [7:0]        rdata;
   logic              rd_en, rd_valid, wr_en;
   logic [15:0]       rd_addr, wr_addr;
   logic [7:0]        rd_data, wr_data;
   logic              resp_valid = 1'b0;
   logic              stray_valid = 1'b0;

   always_comb begin
      for (int i = 0; i < NP; i++) begin
         req_valid[i]         = tb_req_valid[i];
         req_write[i]         = tb_req_write[i];
         req_addr[i*16 +: 16] = tb_addr[i];
         req_len[i*16 +: 16]  = tb_len[i];
         wdata_valid[i]       = tb_wvalid[i];
         wdata[i*8 +: 8]      = tb_wdata[i];
         req_lock[i]          = tb_lock[i];
      end
   end
   assign rd_valid = resp_valid | stray_valid;

   mgmt_bus_arbiter #(
      .NUM_PORTS      (NP),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_write_i   (req_write),
      .req_addr_i    (req_addr),
      .req_len_i     (req_len),
`ifdef MGMT_ARB_LOCK_EN
      .req_lock_i    (req_lock),
`endif
      .wdata_valid_i (wdata_valid),
      .wdata_ready_o (wdata_ready),
      .wdata_i       (wdata),
      .rdata_valid_o (rdata_valid),
      .rdata_o       (rdata),
      .xfer_done_o   (xfer_done),
      .xfer_err_o    (xfer_err),
      .rd_en_o       (rd_en),
      .rd_addr_o     (rd_addr),
      .rd_valid_i    (rd_valid),
      .rd_data_i     (rd_data),
      .wr_en_o       (wr_en),
      .wr_addr_o     (wr_addr),
      .wr_data_o     (wr_data)
   );

   typedef struct { bit wr; logic [15:0] addr; logic [7:0] data; } bus_t;
   typedef struct { int port; logic [7:0] data; } rd_t;
   typedef struct { int port; bit err; } done_t;

   bus_t  exp_bus [$];
   rd_t   exp_rd  [$];
   done_t exp_done[$];

   logic [7:0] wbuf [NP][64];
   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_rd_cyc = 0;
   int model_ptr = 0;
   int fixed_lat = 0;
   int withhold_from = -1;
   int rd_seen = 0;

   // Register-bus contents seen by reads: a fixed function of the address.
   function automatic logic [7:0] pat(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5C;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Burst-level model: which bus accesses, read bytes and completion a burst produces.
   task automatic expect_burst(input int p, input bit wr, input logic [15:0] addr,
                               input logic [15:0] len, input int abort_at, input bit locked);
      bus_t b;
      rd_t  r;
      done_t d;
      for (int i = 0; i < int'(len); i++) begin
         if (abort_at >= 0 && i > abort_at) break;
         b.wr   = wr;
         b.addr = addr + 16'(i);
         b.data = wr ? wbuf[p][i] : 8'h00;
         exp_bus.push_back(b);
         if (!wr && i != abort_at) begin
            r.port = p;
            r.data = pat(b.addr);
            exp_rd.push_back(r);
         end
      end
      d.port = p;
      d.err  = (abort_at >= 0);
      exp_done.push_back(d);
      if (!locked) model_ptr = (p + 1) % NP;
   endtask

   // Register-bus responder.
   int          r_lat;
   logic [15:0] r_addr;
   initial begin
      rd_data = 8'h00;
      forever begin
         @(negedge clk);
         if (rst_n && rd_en) begin
            r_addr = rd_addr;
            r_lat  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, TO));
            rd_seen++;
            if (!(withhold_from >= 0 && rd_seen > withhold_from)) begin
               repeat (r_lat) @(posedge clk);
               #1 resp_valid = 1'b1;
               rd_data = pat(r_addr);
               @(posedge clk);
               #1 resp_valid = 1'b0;
               rd_data = 8'($urandom);
            end
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents something.
   bus_t  mb;
   rd_t   mr;
   done_t md;
   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (rd_en || wr_en) begin
            if (rd_en) last_rd_cyc = cyc;
            if (exp_bus.size() == 0) begin
               chk("bus_unexpected", {wr_en, rd_en}, 2'b00);
            end else begin
               mb = exp_bus.pop_front();
               chk("bus_kind", {wr_en, rd_en}, mb.wr ? 2'b10 : 2'b01);
               chk("bus_addr", wr_en ? wr_addr : rd_addr, mb.addr);
               if (mb.wr) chk("bus_wdata", wr_data, mb.data);
            end
         end
         if (|rdata_valid) begin
            if (exp_rd.size() == 0) begin
               chk("rdv_unexpected", rdata_valid, 0);
            end else begin
               mr = exp_rd.pop_front();
               chk("rdv_port", rdata_valid, NP'(1) << mr.port);
               chk("rdata", rdata, mr.data);
            end
         end
         if (|xfer_done || |xfer_err) begin
            if (exp_done.size() == 0) begin
               chk("done_unexpected", {xfer_done, xfer_err}, 0);
            end else begin
               md = exp_done.pop_front();
               chk("done_port", xfer_done, NP'(1) << md.port);
               chk("err_flag", xfer_err, md.err ? (NP'(1) << md.port) : NP'(0));
               if (md.err) chk("timeout_lat", cyc - last_rd_cyc, TO + 1);
            end
         end
      end
   end

   task automatic run_port(input int p, input bit wr, input logic [15:0] addr, input logic [15:0] len);
      bit ok;
      bit v;
      bit acc;
      int pos;
      @(posedge clk);
      #1;
      tb_req_valid[p] = 1'b1;
      tb_req_write[p] = wr;
      tb_addr[p]      = addr;
      tb_len[p]       = len;
      ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         if (req_ready[p]) begin
            ok = 1'b1;
            chk("ready_onehot", req_ready, NP'(1) << p);
         end
      end
      if (!ok) chk("ready_wait", req_ready[p], 1'b1);
      @(posedge clk);
      #1 tb_req_valid[p] = 1'b0;
      if (wr) begin
         pos = 0;
         for (int i = 0; i < 3000 && pos < int'(len); i++) begin
            v = ($urandom_range(0, 3) != 0);
            tb_wvalid[p] = v;
            tb_wdata[p]  = v ? wbuf[p][pos] : 8'($urandom);
            @(negedge clk);
            acc = v && wdata_ready[p];
            @(posedge clk);
            #1;
            if (acc) pos++;
         end
         tb_wvalid[p] = 1'b0;
         if (pos < int'(len)) chk("wdata_wait", pos, len);
      end
      ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         if (xfer_done[p]) ok = 1'b1;
      end
      if (!ok) chk("done_wait", xfer_done[p], 1'b1);
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         if (exp_bus.size() == 0 && exp_rd.size() == 0 && exp_done.size() == 0) break;
         @(negedge clk);
      end
      chk("left_bus", exp_bus.size(), 0);
      chk("left_rd", exp_rd.size(), 0);
      chk("left_done", exp_done.size(), 0);
   endtask

   task automatic fill(input int p, input int n);
      for (int i = 0; i < n; i++) wbuf[p][i] = 8'($urandom);
   endtask

   function automatic logic [59:0] all_outs();
      return {req_ready, wdata_ready, rdata_valid, rdata, xfer_done, xfer_err,
              rd_en, rd_addr, wr_en, wr_addr, wr_data};
   endfunction

   int          first, second;
   bit          rw   [NP];
   logic [15:0] ra   [NP];
   logic [15:0] rl   [NP];
   int          seen_done;

   initial begin
      for (int i = 0; i < NP; i++) begin
         tb_req_valid[i] = 1'b0; tb_req_write[i] = 1'b0; tb_addr[i] = '0;
         tb_len[i] = '0; tb_wvalid[i] = 1'b0; tb_wdata[i] = '0; tb_lock[i] = 1'b0;
      end
      #1 chk("reset_outputs", all_outs(), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Simultaneous requests from reset, then a back-to-back port0 request.
      fixed_lat = 1;
      fill(1, 2);
      expect_burst(0, 1'b0, 16'h0100, 16'd2, -1, 1'b0);
      expect_burst(1, 1'b1, 16'h0300, 16'd2, -1, 1'b0);
      expect_burst(0, 1'b0, 16'h0120, 16'd1, -1, 1'b0);
      fork
         begin
            run_port(0, 1'b0, 16'h0100, 16'd2);
            run_port(0, 1'b0, 16'h0120, 16'd1);
         end
         run_port(1, 1'b1, 16'h0300, 16'd2);
      join
      drain();

      fixed_lat = 2;
      expect_burst(0, 1'b0, 16'h0010, 16'd3, -1, 1'b0);
      run_port(0, 1'b0, 16'h0010, 16'd3);
      drain();

      wbuf[1][0] = 8'hA5; wbuf[1][1] = 8'h5A; wbuf[1][2] = 8'hC3;
      expect_burst(1, 1'b1, 16'hFFFE, 16'd3, -1, 1'b0);
      run_port(1, 1'b1, 16'hFFFE, 16'd3);
      drain();

      // Second read never answered: abort with error after TO wait cycles.
      rd_seen = 0;
      withhold_from = 1;
      expect_burst(0, 1'b0, 16'h0200, 16'd2, 1, 1'b0);
      run_port(0, 1'b0, 16'h0200, 16'd2);
      drain();
      withhold_from = -1;

      // Response on the last permitted wait cycle must be accepted.
      fixed_lat = TO;
      expect_burst(1, 1'b0, 16'h0A00, 16'd2, -1, 1'b0);
      run_port(1, 1'b0, 16'h0A00, 16'd2);
      drain();
      fixed_lat = 0;

      expect_burst(1, 1'b0, 16'h4444, 16'd0, -1, 1'b0);
      run_port(1, 1'b0, 16'h4444, 16'd0);
      drain();

      // Stray rd_valid while idle must not produce read data.
      @(posedge clk); #1 stray_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1 stray_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("stray_rdv", rdata_valid, 0);

      for (int it = 0; it < 40; it++) begin
         for (int p = 0; p < NP; p++) begin
            rw[p] = 1'($urandom_range(0, 1));
            rl[p] = 16'($urandom_range(0, 6));
            ra[p] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF))
                                                 : 16'($urandom);
            fill(p, int'(rl[p]));
         end
         if ($urandom_range(0, 2) == 0) begin
            first  = model_ptr;
            second = (first + 1) % NP;
            expect_burst(first, rw[first], ra[first], rl[first], -1, 1'b0);
            expect_burst(second, rw[second], ra[second], rl[second], -1, 1'b0);
            fork
               run_port(0, rw[0], ra[0], rl[0]);
               run_port(1, rw[1], ra[1], rl[1]);
            join
         end else begin
            first = int'($urandom_range(0, NP - 1));
            expect_burst(first, rw[first], ra[first], rl[first], -1, 1'b0);
            run_port(first, rw[first], ra[first], rl[first]);
         end
      end
      drain();

      // Reset in the middle of a write burst.
      fill(0, 4);
      exp_bus.push_back('{wr: 1'b1, addr: 16'h1234, data: wbuf[0][0]});
      @(posedge clk); #1;
      tb_req_valid[0] = 1'b1; tb_req_write[0] = 1'b1; tb_addr[0] = 16'h1234; tb_len[0] = 16'd4;
      for (int i = 0; i < 200 && !req_ready[0]; i++) @(negedge clk);
      chk("rst_ready", req_ready[0], 1'b1);
      @(posedge clk); #1;
      tb_req_valid[0] = 1'b0;
      tb_wvalid[0] = 1'b1; tb_wdata[0] = wbuf[0][0];
      @(posedge clk); #1 tb_wvalid[0] = 1'b0;
      @(negedge clk);
      chk("pre_rst_wready", wdata_ready, 2'b01);
      #2 rst_n = 1'b0;
      #1 chk("mid_burst_reset", all_outs(), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_ptr = 0;
      seen_done = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (|xfer_done) seen_done++;
      end
      chk("no_done_after_rst", seen_done, 0);
      drain();

`ifdef MGMT_ARB_LOCK_EN
      // Locked read then write on port0 while port1 requests throughout.
      fixed_lat = 1;
      fill(0, 2);
      expect_burst(0, 1'b0, 16'h0500, 16'd2, -1, 1'b1);
      expect_burst(0, 1'b1, 16'h0500, 16'd2, -1, 1'b1);
      expect_burst(1, 1'b0, 16'h0600, 16'd1, -1, 1'b0);
      tb_lock[0] = 1'b1;
      fork
         begin
            run_port(0, 1'b0, 16'h0500, 16'd2);
            run_port(0, 1'b1, 16'h0500, 16'd2);
            @(posedge clk);
            #1 tb_lock[0] = 1'b0;
         end
         run_port(1, 1'b0, 16'h0600, 16'd1);
      join
      drain();
      fixed_lat = 0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
